wd_safe_shutdown: RTL and testbench

Consumes the watchdog timer's `warning` and `triggered` outputs and gates the AM carrier amplitude sent to the DAC/modulator path.
- Warning: amplitude is attenuated.
- Trigger: amplitude is ramped to zero, RF is disabled and a fault is latched until software clears it.
- Clear and reset exits use a soft-start ramp-up to avoid spectral splatter.

---
 rtl/wd_safe_shutdown_if.sv | 22 ++
 rtl/wd_safe_shutdown.sv | 104 ++++++++++
 tb/tb_wd_safe_shutdown.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wd_safe_shutdown_if.sv
// wd_safe_shutdown_if: watchdog inputs and gated-amplitude outputs of the safe-shutdown block
// master drives wd_warning/wd_triggered/fault_clear/amp_target and observes the rest;
// slave (the shutdown block) drives amp_out/rf_enable/fault_latched/state_o/shutdown_count.
interface wd_safe_shutdown_if #(parameter int AMP_W = 16);
  logic             wd_warning;
  logic             wd_triggered;
  logic             fault_clear;
  logic [AMP_W-1:0] amp_target;
  logic [AMP_W-1:0] amp_out;
  logic             rf_enable;
  logic             fault_latched;
  logic [2:0]       state_o;
  logic [7:0]       shutdown_count;
  modport master(
    output wd_warning, wd_triggered, fault_clear, amp_target,
    input  amp_out, rf_enable, fault_latched, state_o, shutdown_count
  );
  modport slave(
    input  wd_warning, wd_triggered, fault_clear, amp_target,
    output amp_out, rf_enable, fault_latched, state_o, shutdown_count
  );
endinterface

// File: rtl/wd_safe_shutdown.sv
// wd_safe_shutdown: gates AM carrier amplitude from watchdog warning/trigger with soft ramps
// clk, rstn (async active-low); bus.slave carries watchdog levels, fault_clear, amp_target in
// and registered amp_out, rf_enable, fault_latched, state_o, shutdown_count out.
module wd_safe_shutdown #(
  parameter int AMP_W      = 16,
  parameter int RAMP_STEP  = 256,
  parameter int RAMP_DIV   = 4,
  parameter int WARN_SHIFT = 1
) (
  input logic clk,
  input logic rstn,
  wd_safe_shutdown_if.slave bus
);
  typedef enum logic [2:0] {RUN = 3'd0, WARN = 3'd1, RAMP_DOWN = 3'd2, MUTED = 3'd3, RAMP_UP = 3'd4} state_t;
  localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(RAMP_DIV - 1);
  localparam logic [AMP_W:0] STEP = (AMP_W + 1)'(RAMP_STEP);
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [AMP_W-1:0] amp, amp_n;
  logic rf, rf_n, flt, flt_n, step;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic [AMP_W:0] amp_x, tgt_x, up_sum, dn;
  // Ramp arithmetic is one bit wider so neither direction can wrap.
  assign amp_x   = {1'b0, amp};
  assign tgt_x   = {1'b0, bus.amp_target};
  assign up_sum  = amp_x + STEP;
  assign dn      = amp_x < STEP ? '0 : amp_x - STEP;
  assign step    = pre == P_LAST;
  assign cnt_inc = cnt == 8'hff ? cnt : cnt + 8'd1;
  always_comb begin
    state_n = state;
    amp_n   = amp;
    rf_n    = rf;
    flt_n   = flt;
    cnt_n   = cnt;
    case (state)
      RUN, WARN: begin
        rf_n = 1'b1;
        if (bus.wd_triggered) begin
          state_n = RAMP_DOWN;
          cnt_n   = cnt_inc;
        end else if (bus.wd_warning) begin
          state_n = WARN;
          amp_n   = bus.amp_target >> WARN_SHIFT;
        end else begin
          state_n = RUN;
          amp_n   = bus.amp_target;
        end
      end
      RAMP_DOWN: if (step) begin
        amp_n = dn[AMP_W-1:0];
        if (dn == '0) begin
          state_n = MUTED;
          rf_n    = 1'b0;
          flt_n   = 1'b1;
        end
      end
      MUTED: begin
        amp_n = '0;
        rf_n  = 1'b0;
        // A clear arriving while still triggered is dropped, not remembered.
        if (bus.fault_clear && !bus.wd_triggered) begin
          state_n = RAMP_UP;
          rf_n    = 1'b1;
          flt_n   = 1'b0;
        end
      end
      RAMP_UP: begin
        rf_n = 1'b1;
        if (bus.wd_triggered) begin
          state_n = RAMP_DOWN;
          cnt_n   = cnt_inc;
        end else if (amp_x >= tgt_x || (step && up_sum >= tgt_x)) begin
          state_n = RUN;
          amp_n   = bus.amp_target;
        end else if (step) amp_n = up_sum[AMP_W-1:0];
      end
      default: state_n = RAMP_UP;
    endcase
    pre_n = (state_n != state || step) ? '0 : pre + 1'b1;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= RAMP_UP;
      pre   <= '0;
      amp   <= '0;
      rf    <= 1'b0;
      flt   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      amp   <= amp_n;
      rf    <= rf_n;
      flt   <= flt_n;
      cnt   <= cnt_n;
    end
  assign bus.amp_out        = amp;
  assign bus.rf_enable      = rf;
  assign bus.fault_latched  = flt;
  assign bus.state_o        = state;
  assign bus.shutdown_count = cnt;
endmodule

// File: tb/tb_wd_safe_shutdown.sv
// tb_wd_safe_shutdown: directed walk-through plus randomized watchdog traffic against a reference model
module tb_wd_safe_shutdown;
  localparam int AW = 16, STEP = 256, DIV = 4, WS = 1;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  wd_safe_shutdown_if #(.AMP_W(AW)) bus();
  wd_safe_shutdown #(.AMP_W(AW), .RAMP_STEP(STEP), .RAMP_DIV(DIV), .WARN_SHIFT(WS)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );
  int compared = 0, mismatched = 0;
  int m_state, m_amp, m_rf, m_fault, m_cnt, m_age;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_state = 4; m_amp = 0; m_rf = 0; m_fault = 0; m_cnt = 0; m_age = 0;
  endtask
  // Behavioural view: a ramp step lands every DIV-th edge spent in a state.
  task automatic model_edge();
    int t, ns;
    bit stp;
    t   = int'(bus.amp_target);
    stp = (m_age % DIV) == DIV - 1;
    ns  = m_state;
    case (m_state)
      0, 1: begin
        m_rf = 1;
        if (bus.wd_triggered) begin ns = 2; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255; end
        else if (bus.wd_warning) begin ns = 1; m_amp = t >> WS; end
        else begin ns = 0; m_amp = t; end
      end
      2: if (stp) begin
        m_amp = m_amp > STEP ? m_amp - STEP : 0;
        if (m_amp == 0) begin ns = 3; m_rf = 0; m_fault = 1; end
      end
      3: begin
        m_amp = 0; m_rf = 0;
        if (bus.fault_clear && !bus.wd_triggered) begin ns = 4; m_rf = 1; m_fault = 0; end
      end
      default: begin
        m_rf = 1;
        if (bus.wd_triggered) begin ns = 2; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255; end
        else if (m_amp >= t) begin m_amp = t; ns = 0; end
        else if (stp) begin
          m_amp = m_amp + STEP < t ? m_amp + STEP : t;
          if (m_amp == t) ns = 0;
        end
      end
    endcase
    m_age = ns != m_state ? 0 : m_age + 1;
    m_state = ns;
  endtask
  task automatic check_all();
    chk("amp_out", 32'(bus.amp_out), 32'(m_amp));
    chk("rf_enable", 32'(bus.rf_enable), 32'(m_rf));
    chk("fault_latched", 32'(bus.fault_latched), 32'(m_fault));
    chk("state_o", 32'(bus.state_o), 32'(m_state));
    chk("shutdown_count", 32'(bus.shutdown_count), 32'(m_cnt));
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rstn) model_edge();
      #1 check_all();
      bus.fault_clear = 1'b0;
    end
  endtask
  // Assert reset between edges and check outputs drop without waiting for a clock.
  task automatic async_reset();
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all();
    chk("async_rst_amp", 32'(bus.amp_out), 32'd0);
    cyc(2);
    @(negedge clk) rstn = 1'b1;
  endtask
  initial begin
    bus.wd_warning = 1'b0; bus.wd_triggered = 1'b0; bus.fault_clear = 1'b0; bus.amp_target = 16'h1000;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rstn = 1'b1;
    cyc(64);
    chk("rampup_done_amp", 32'(bus.amp_out), 32'h1000);
    chk("rampup_done_state", 32'(bus.state_o), 32'd0);
    bus.wd_warning = 1'b1; cyc(10);
    chk("warn_amp", 32'(bus.amp_out), 32'h0800);
    bus.wd_warning = 1'b0; cyc(3);
    chk("warn_exit_amp", 32'(bus.amp_out), 32'h1000);
    chk("warn_no_count", 32'(bus.shutdown_count), 32'd0);
    bus.wd_warning = 1'b1; cyc(2);
    bus.wd_triggered = 1'b1; cyc(40);
    chk("muted_state", 32'(bus.state_o), 32'd3);
    chk("muted_fault", 32'(bus.fault_latched), 32'd1);
    chk("muted_count", 32'(bus.shutdown_count), 32'd1);
    bus.wd_warning = 1'b0;
    bus.fault_clear = 1'b1; cyc(4);
    chk("clear_dropped", 32'(bus.state_o), 32'd3);
    bus.wd_triggered = 1'b0; cyc(2);
    bus.fault_clear = 1'b1; cyc(1);
    chk("clear_fault", 32'(bus.fault_latched), 32'd0);
    chk("clear_rf", 32'(bus.rf_enable), 32'd1);
    cyc(32);
    chk("reramp_amp", 32'(bus.amp_out), 32'h0800);
    bus.wd_triggered = 1'b1; cyc(9);
    chk("rd_amp", 32'(bus.amp_out), 32'h0600);
    chk("rd_count", 32'(bus.shutdown_count), 32'd2);
    bus.wd_triggered = 1'b0;
    async_reset();
    chk("rst_state", 32'(bus.state_o), 32'd4);
    cyc(16);
    chk("pre_lower_amp", 32'(bus.amp_out), 32'h0400);
    bus.amp_target = 16'h0300; cyc(1);
    chk("lower_amp", 32'(bus.amp_out), 32'h0300);
    chk("lower_state", 32'(bus.state_o), 32'd0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) bus.wd_triggered = ~bus.wd_triggered;
      if ($urandom_range(14) == 0) bus.wd_warning = ~bus.wd_warning;
      bus.fault_clear = $urandom_range(9) == 0;
      if ($urandom_range(59) == 0)
        case ($urandom_range(3))
          0: bus.amp_target = '0;
          1: bus.amp_target = 16'hffff;
          2: bus.amp_target = 16'($urandom_range(1023));
          default: bus.amp_target = 16'($urandom);
        endcase
      if ($urandom_range(499) == 0) async_reset();
      else cyc(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
